// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit
// Program-counter / fetch sequencer for the 9-bit core.
//
// Drives ProgCtr into the instruction ROM. It picks the next PC from the
// decoded control of the instruction currently on the ROM output: fall through
// to PC+1, branch to an entry of a small loadable target LUT, or halt. It also
// runs the Start/Done handshake and counts retired instructions.
//
// Ports
//   Clk           in   clock, rising edge
//   Reset         in   asynchronous, active-low reset
//   Start         in   launch a program (sampled in IDLE/HALT)
//   Stall         in   freeze fetch for this cycle while running
//   JumpEqual     in   decoded je
//   JumpNotEqual  in   decoded jne
//   EqFlag        in   ALU equal flag for the current instruction
//   TargSel       in   target LUT index for je/jne
//   Ack           in   decoded halt instruction
//   LutWrEn       in   target LUT write enable
//   LutWrAddr     in   target LUT write index
//   LutWrData     in   target LUT write data (absolute target)
//   ProgCtr       out  instruction ROM address
//   InstrValid    out  high while running (ROM output is a live instruction)
//   Done          out  high while halted
//   InstrCount    out  retired instructions since the last Start (saturating)
// ============================================================================
module fetch_unit #(
    parameter int unsigned PC_W       = 10,
    parameter int unsigned START_ADDR = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Stall,
    input  logic              JumpEqual,
    input  logic              JumpNotEqual,
    input  logic              EqFlag,
    input  logic [1:0]        TargSel,
    input  logic              Ack,
    input  logic              LutWrEn,
    input  logic [1:0]        LutWrAddr,
    input  logic [PC_W-1:0]   LutWrData,
    output logic [PC_W-1:0]   ProgCtr,
    output logic              InstrValid,
    output logic              Done,
    output logic [CNT_W-1:0]  InstrCount
);

    localparam int unsigned LUT_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e             state_q;
    logic [PC_W-1:0]    pc_q;
    logic               valid_q;
    logic               done_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [PC_W-1:0]    lut_q [LUT_DEPTH];

    logic               taken_c;
    logic [PC_W-1:0]    pc_inc_c;
    logic [PC_W-1:0]    target_c;
    logic [CNT_W-1:0]   cnt_inc_c;
    logic [PC_W-1:0]    start_pc_c;

    // Branch decision; je and jne together form an unconditional jump.
    assign taken_c    = (JumpEqual & EqFlag) | (JumpNotEqual & ~EqFlag);

    // Read-before-write: the target comes from the registered LUT, so a write
    // landing on the same edge is not yet visible to this branch.
    assign target_c   = lut_q[TargSel];

    // Sequential fetch wraps naturally at 2**PC_W.
    assign pc_inc_c   = pc_q + PC_W'(1);

    // Retired count saturates at all-ones.
    assign cnt_inc_c  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    assign start_pc_c = PC_W'(START_ADDR);

    // Fetch FSM, PC, counter, handshake outputs and target LUT.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            for (int i = 0; i < int'(LUT_DEPTH); i++) begin
                lut_q[i] <= '0;
            end
        end else begin
            if (LutWrEn) begin
                lut_q[LutWrAddr] <= LutWrData;
            end

            case (state_q)
                ST_IDLE, ST_HALT: begin
                    if (Start) begin
                        state_q <= ST_RUN;
                        pc_q    <= start_pc_c;
                        cnt_q   <= '0;
                        valid_q <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end

                ST_RUN: begin
                    // A stalled cycle retires nothing and ignores all control.
                    if (!Stall) begin
                        cnt_q <= cnt_inc_c;
                        if (Ack) begin
                            // Halt keeps the halt address on ProgCtr.
                            state_q <= ST_HALT;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (taken_c) begin
                            pc_q <= target_c;
                        end else begin
                            pc_q <= pc_inc_c;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ProgCtr    = pc_q;
    assign InstrValid = valid_q;
    assign Done       = done_q;
    assign InstrCount = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit
// Self-checking bench for fetch_unit. A behavioural model (plain integers and
// an array for the target LUT) is stepped once per clock from the same inputs
// the DUT sees; directed scenarios also compare against literal constants.
// A narrow counter width is used so that saturation is reachable quickly.
// ============================================================================
module tb_fetch_unit;

    localparam int unsigned PC_W       = 10;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned START_ADDR = 0;
    localparam int unsigned PC_MOD     = 1 << PC_W;
    localparam int unsigned CNT_MAX    = (1 << CNT_W) - 1;
    localparam int unsigned VW         = PC_W + CNT_W + 2;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              Start;
    logic              Stall;
    logic              JumpEqual;
    logic              JumpNotEqual;
    logic              EqFlag;
    logic [1:0]        TargSel;
    logic              Ack;
    logic              LutWrEn;
    logic [1:0]        LutWrAddr;
    logic [PC_W-1:0]   LutWrData;
    logic [PC_W-1:0]   ProgCtr;
    logic              InstrValid;
    logic              Done;
    logic [CNT_W-1:0]  InstrCount;

    int errors = 0;
    int checks = 0;

    // Behavioural model state.
    int          m_state;
    int unsigned m_pc;
    int unsigned m_cnt;
    int unsigned m_lut [4];

    wire [VW-1:0] dut_vec = {ProgCtr, InstrValid, Done, InstrCount};

    fetch_unit #(
        .PC_W       (PC_W),
        .START_ADDR (START_ADDR),
        .CNT_W      (CNT_W)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start        (Start),
        .Stall        (Stall),
        .JumpEqual    (JumpEqual),
        .JumpNotEqual (JumpNotEqual),
        .EqFlag       (EqFlag),
        .TargSel      (TargSel),
        .Ack          (Ack),
        .LutWrEn      (LutWrEn),
        .LutWrAddr    (LutWrAddr),
        .LutWrData    (LutWrData),
        .ProgCtr      (ProgCtr),
        .InstrValid   (InstrValid),
        .Done         (Done),
        .InstrCount   (InstrCount)
    );

    always #5 Clk = ~Clk;

    function automatic void model_reset();
        m_state = M_IDLE;
        m_pc    = 0;
        m_cnt   = 0;
        for (int i = 0; i < 4; i++) m_lut[i] = 0;
    endfunction

    // One clock of the program-counter rules, from the current inputs.
    function automatic void model_step();
        int unsigned old_target;
        old_target = m_lut[TargSel];
        if (m_state != M_RUN) begin
            if (Start) begin
                m_state = M_RUN;
                m_pc    = START_ADDR;
                m_cnt   = 0;
            end
        end else if (!Stall) begin
            if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            if (Ack)
                m_state = M_HALT;
            else if ((JumpEqual && EqFlag) || (JumpNotEqual && !EqFlag))
                m_pc = old_target;
            else
                m_pc = (m_pc + 1) % PC_MOD;
        end
        if (LutWrEn) m_lut[LutWrAddr] = 32'(LutWrData);
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {PC_W'(m_pc), (m_state == M_RUN), (m_state == M_HALT), CNT_W'(m_cnt)};
    endfunction

    task automatic clear_inputs();
        Start        = 1'b0;
        Stall        = 1'b0;
        JumpEqual    = 1'b0;
        JumpNotEqual = 1'b0;
        EqFlag       = 1'b0;
        TargSel      = 2'd0;
        Ack          = 1'b0;
        LutWrEn      = 1'b0;
        LutWrAddr    = 2'd0;
        LutWrData    = '0;
    endtask

    // Advance model and DUT by one edge; outputs are sampled 1 time unit later.
    task automatic tick();
        model_step();
        @(posedge Clk);
        #1;
    endtask

    task automatic advance(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        clear_inputs();
        model_reset();
        #2;
        Reset = 1'b1;
    endtask

    task automatic launch();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic write_lut(input logic [1:0] a, input logic [PC_W-1:0] d);
        LutWrEn   = 1'b1;
        LutWrAddr = a;
        LutWrData = d;
        tick();
        LutWrEn   = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        clear_inputs();
        model_reset();
        #3;
        checks++;
        if (dut_vec !== {VW{1'b0}}) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", dut_vec, {VW{1'b0}});
        end
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL idle_after_reset: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_sequential();
        do_reset();
        launch();
        checks++;
        if (ProgCtr !== 10'd0 || InstrValid !== 1'b1 || InstrCount !== 4'd0) begin
            errors++;
            $display("FAIL seq_start: got pc=%h v=%b cnt=%0d want pc=000 v=1 cnt=0",
                     ProgCtr, InstrValid, InstrCount);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (ProgCtr !== PC_W'(i) || InstrCount !== CNT_W'(i) || dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL seq_step%0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_branch();
        do_reset();
        write_lut(2'd2, 10'h040);
        launch();
        advance(5);
        JumpEqual = 1'b1; EqFlag = 1'b1; TargSel = 2'd2;
        tick();
        clear_inputs();
        checks++;
        if (ProgCtr !== 10'h040 || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL je_taken: got pc=%h want pc=040", ProgCtr);
        end

        do_reset();
        write_lut(2'd2, 10'h040);
        launch();
        advance(5);
        JumpEqual = 1'b1; EqFlag = 1'b0; TargSel = 2'd2;
        tick();
        clear_inputs();
        checks++;
        if (ProgCtr !== 10'd6 || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL je_not_taken: got pc=%h want pc=006", ProgCtr);
        end

        // je+jne together jumps regardless of the flag.
        JumpEqual = 1'b1; JumpNotEqual = 1'b1; EqFlag = 1'b0; TargSel = 2'd2;
        tick();
        clear_inputs();
        checks++;
        if (ProgCtr !== 10'h040) begin
            errors++;
            $display("FAIL je_jne_uncond: got pc=%h want pc=040", ProgCtr);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        write_lut(2'd1, 10'h3FF);
        launch();
        JumpNotEqual = 1'b1; EqFlag = 1'b0; TargSel = 2'd1;
        tick();
        clear_inputs();
        checks++;
        if (ProgCtr !== 10'h3FF) begin
            errors++;
            $display("FAIL jne_taken: got pc=%h want pc=3ff", ProgCtr);
        end
        tick();
        checks++;
        if (ProgCtr !== 10'h000 || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL pc_wrap: got pc=%h want pc=000", ProgCtr);
        end
    endtask

    task automatic test_halt();
        do_reset();
        write_lut(2'd0, 10'h123);
        launch();
        advance(9);
        Ack = 1'b1; JumpEqual = 1'b1; EqFlag = 1'b1; TargSel = 2'd0;
        tick();
        clear_inputs();
        checks++;
        if (ProgCtr !== 10'd9 || Done !== 1'b1 || InstrValid !== 1'b0 || InstrCount !== 4'd10) begin
            errors++;
            $display("FAIL halt_priority: got pc=%h d=%b v=%b cnt=%0d want pc=009 d=1 v=0 cnt=10",
                     ProgCtr, Done, InstrValid, InstrCount);
        end
        advance(3);
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL halt_hold: got %h want %h", dut_vec, exp_vec());
        end
        launch();
        checks++;
        if (ProgCtr !== 10'd0 || Done !== 1'b0 || InstrCount !== 4'd0 || InstrValid !== 1'b1) begin
            errors++;
            $display("FAIL restart: got pc=%h d=%b cnt=%0d v=%b want pc=000 d=0 cnt=0 v=1",
                     ProgCtr, Done, InstrCount, InstrValid);
        end
        // Start while running is ignored.
        Start = 1'b1;
        advance(2);
        Start = 1'b0;
        checks++;
        if (ProgCtr !== 10'd2 || InstrCount !== 4'd2) begin
            errors++;
            $display("FAIL start_in_run: got pc=%h cnt=%0d want pc=002 cnt=2", ProgCtr, InstrCount);
        end
    endtask

    task automatic test_stall();
        do_reset();
        launch();
        advance(7);
        Stall = 1'b1; Ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ProgCtr !== 10'd7 || InstrCount !== 4'd7 || Done !== 1'b0 || InstrValid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold%0d: got pc=%h cnt=%0d d=%b want pc=007 cnt=7 d=0",
                         i, ProgCtr, InstrCount, Done);
            end
        end
        Stall = 1'b0;
        tick();
        clear_inputs();
        checks++;
        if (ProgCtr !== 10'd7 || Done !== 1'b1 || InstrCount !== 4'd8) begin
            errors++;
            $display("FAIL stall_release_halt: got pc=%h d=%b cnt=%0d want pc=007 d=1 cnt=8",
                     ProgCtr, Done, InstrCount);
        end
        // Stall does not block Start from HALT.
        Stall = 1'b1; Start = 1'b1;
        tick();
        clear_inputs();
        checks++;
        if (InstrValid !== 1'b1 || Done !== 1'b0 || ProgCtr !== 10'd0) begin
            errors++;
            $display("FAIL stall_start: got v=%b d=%b pc=%h want v=1 d=0 pc=000",
                     InstrValid, Done, ProgCtr);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        launch();
        advance(20);
        checks++;
        if (InstrCount !== 4'hF || ProgCtr !== 10'd20 || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL cnt_saturate: got cnt=%0d pc=%h want cnt=15 pc=014", InstrCount, ProgCtr);
        end
    endtask

    task automatic test_lut_collision_and_reset();
        do_reset();
        write_lut(2'd0, 10'h010);
        launch();
        advance(2);
        JumpEqual = 1'b1; EqFlag = 1'b1; TargSel = 2'd0;
        LutWrEn = 1'b1; LutWrAddr = 2'd0; LutWrData = 10'h020;
        tick();
        clear_inputs();
        checks++;
        if (ProgCtr !== 10'h010) begin
            errors++;
            $display("FAIL lut_old_value: got pc=%h want pc=010", ProgCtr);
        end
        JumpEqual = 1'b1; EqFlag = 1'b1; TargSel = 2'd0;
        tick();
        clear_inputs();
        checks++;
        if (ProgCtr !== 10'h020) begin
            errors++;
            $display("FAIL lut_new_value: got pc=%h want pc=020", ProgCtr);
        end
        // Asynchronous reset mid-run, observed before any clock edge.
        Reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec !== {VW{1'b0}}) begin
            errors++;
            $display("FAIL reset_mid_run: got %h want %h", dut_vec, {VW{1'b0}});
        end
        Reset = 1'b1;
        launch();
        JumpEqual = 1'b1; EqFlag = 1'b1; TargSel = 2'd0;
        tick();
        clear_inputs();
        checks++;
        if (ProgCtr !== 10'h000) begin
            errors++;
            $display("FAIL lut_cleared: got pc=%h want pc=000", ProgCtr);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            Start        = ($urandom_range(7) == 0);
            Stall        = ($urandom_range(3) == 0);
            JumpEqual    = ($urandom_range(3) == 0);
            JumpNotEqual = ($urandom_range(3) == 0);
            EqFlag       = 1'($urandom);
            TargSel      = 2'($urandom);
            Ack          = ($urandom_range(15) == 0);
            LutWrEn      = ($urandom_range(3) == 0);
            LutWrAddr    = 2'($urandom);
            LutWrData    = PC_W'($urandom);
            if ($urandom_range(149) == 0) begin
                Reset = 1'b0;
                model_reset();
                #1;
                Reset = 1'b1;
            end
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random_cycle%0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_wrap();
        test_halt();
        test_stall();
        test_saturate();
        test_lut_collision_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
